mips_perf_counters: RTL and testbench



---
 rtl/mips_perf_pkg.sv | 43 ++++
 rtl/mips_perf_counters_perf_counter.sv | 65 ++++++
 rtl/mips_perf_counters.sv | 150 +++++++++++++++
 tb/tb_mips_perf_counters.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_perf_pkg.sv
// ============================================================================
// Module  : mips_perf_pkg
// Purpose : Shared types and counter index map for the MIPS-Lite performance
//           counter unit.
//           - instr_class_e : instruction class reported at retire
//           - perf_state_e  : counting-controller state
//           - IDX_*         : counter bank indices (read address map)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_perf_pkg;

  typedef enum logic [2:0] {
    CLS_ARITH  = 3'd0,
    CLS_LOGIC  = 3'd1,
    CLS_MEM    = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_HALT   = 3'd4,
    CLS_NOP    = 3'd5
  } instr_class_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } perf_state_e;

  // Counter bank map; generic event channels start at IDX_EXT_BASE.
  localparam int IDX_CYCLES      = 0;
  localparam int IDX_INSTR_TOTAL = 1;
  localparam int IDX_ARITH       = 2;
  localparam int IDX_LOGIC       = 3;
  localparam int IDX_MEM         = 4;
  localparam int IDX_CTRL        = 5;
  localparam int IDX_BR_TAKEN    = 6;
  localparam int IDX_STALL_CYC   = 7;
  localparam int IDX_HAZARDS     = 8;
  localparam int IDX_EXT_BASE    = 9;

endpackage

`default_nettype wire

// File: rtl/mips_perf_counters_perf_counter.sv
// ============================================================================
// Module  : perf_counter
// Purpose : One event counter with synchronous clear, saturate-or-wrap
//           behaviour and a sticky overflow flag.
// Ports   : clock, reset_n (async, active-low)
//           clear_i  - zero counter and overflow flag
//           inc_i    - add one this cycle
//           next_o   - value after this cycle's increment, ignoring clear
//                      (used to capture snapshots taken alongside a clear)
//           ovf_o    - sticky overflow flag
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_counter #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] next_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             ovf_q;
  logic             ovf_hit;

  always_comb begin
    count_d = count_q;
    ovf_hit = 1'b0;
    if (inc_i) begin
      if (&count_q) begin
        ovf_hit = 1'b1;
        count_d = SATURATE ? count_q : '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clear_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (ovf_hit) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign next_o = count_d;
  assign ovf_o  = ovf_q;

endmodule

`default_nettype wire

// File: rtl/mips_perf_counters.sv
// ============================================================================
// Module  : mips_perf_counters
// Purpose : Performance-statistics unit for the MIPS-Lite pipelines. Counts
//           cycles, retired instructions by class, taken branches, stalls,
//           hazards and N_EXT generic events; captures them into a shadow
//           bank on request and reads the shadow through a registered port.
// Ports   : clock, reset_n (async, active-low), clear, enable
//           retire_valid/retire_class/branch_taken - retire information
//           stall, hazard_new, ext_evt            - event inputs
//           snap_req / snap_done                  - snapshot handshake
//           rd_addr / rd_data                     - shadow read, 1-cycle latency
//           ovf                                   - sticky live overflow flags
//           done                                  - halt retired, counting stopped
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_perf_counters
  import mips_perf_pkg::*;
#(
  parameter  int CNT_W    = 32,
  parameter  int N_EXT    = 4,
  parameter  bit SATURATE = 1'b1,
  localparam int NUM_CNT  = IDX_EXT_BASE + N_EXT,
  localparam int ADDR_W   = $clog2(NUM_CNT)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               enable,
  input  logic               retire_valid,
  input  logic [2:0]         retire_class,
  input  logic               branch_taken,
  input  logic               stall,
  input  logic               hazard_new,
  input  logic [N_EXT-1:0]   ext_evt,
  input  logic               snap_req,
  output logic               snap_done,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [CNT_W-1:0]   rd_data,
  output logic [NUM_CNT-1:0] ovf,
  output logic               done
);

  perf_state_e      state_q, state_d;
  logic             counting;
  logic [NUM_CNT-1:0] inc;
  logic [CNT_W-1:0] next_val [NUM_CNT];
  logic [CNT_W-1:0] shadow_q [NUM_CNT];
  logic             snap_done_q;
  logic [CNT_W-1:0] rd_data_q;
  logic [CNT_W-1:0] rd_data_d;

  assign counting = (state_q == ST_RUN) && enable;

  // Per-counter increment strobes; all zero outside counting cycles.
  always_comb begin
    inc = '0;
    if (counting) begin
      inc[IDX_CYCLES]      = 1'b1;
      inc[IDX_INSTR_TOTAL] = retire_valid;
      inc[IDX_ARITH]       = retire_valid && (retire_class == CLS_ARITH);
      inc[IDX_LOGIC]       = retire_valid && (retire_class == CLS_LOGIC);
      inc[IDX_MEM]         = retire_valid && (retire_class == CLS_MEM);
      inc[IDX_CTRL]        = retire_valid && ((retire_class == CLS_BRANCH) ||
                                              (retire_class == CLS_HALT));
      inc[IDX_BR_TAKEN]    = retire_valid && (retire_class == CLS_BRANCH) && branch_taken;
      inc[IDX_STALL_CYC]   = stall;
      inc[IDX_HAZARDS]     = hazard_new;
      inc[IDX_EXT_BASE +: N_EXT] = ext_evt;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (enable) state_d = ST_RUN;
      ST_RUN:    if (counting && retire_valid && (retire_class == CLS_HALT)) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    perf_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .clear_i (clear),
      .inc_i   (inc[gi]),
      .next_o  (next_val[gi]),
      .ovf_o   (ovf[gi])
    );
  end

  // Snapshot takes the post-increment, pre-clear values of this cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow_q[i] <= '0;
      end
      snap_done_q <= 1'b0;
    end else begin
      if (snap_req) begin
        for (int i = 0; i < NUM_CNT; i++) begin
          shadow_q[i] <= next_val[i];
        end
      end
      snap_done_q <= snap_req;
    end
  end

  // Decoded read mux so unmapped addresses return zero.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_data_d = shadow_q[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign snap_done = snap_done_q;
  assign rd_data   = rd_data_q;
  assign done      = (state_q == ST_HALTED);

endmodule

`default_nettype wire

// File: tb/tb_mips_perf_counters.sv
`default_nettype none

module tb_mips_perf_counters;

  localparam int N_EXT = 4;
  localparam int NC    = 13;
  localparam int AW    = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b1;
  logic             clear = 1'b0;
  logic             enable = 1'b0;
  logic             retire_valid = 1'b0;
  logic [2:0]       retire_class = 3'd0;
  logic             branch_taken = 1'b0;
  logic             stall = 1'b0;
  logic             hazard_new = 1'b0;
  logic [N_EXT-1:0] ext_evt = '0;
  logic             snap_req = 1'b0;
  logic [AW-1:0]    rd_addr = '0;

  logic          snap_done_a, snap_done_s, snap_done_w;
  logic [31:0]   rd_data_a;
  logic [3:0]    rd_data_s, rd_data_w;
  logic [NC-1:0] ovf_a, ovf_s, ovf_w;
  logic          done_a, done_s, done_w;

  always #5 clock = ~clock;

  mips_perf_counters dut_a (
    .clock(clock), .reset_n(reset_n), .clear(clear), .enable(enable),
    .retire_valid(retire_valid), .retire_class(retire_class), .branch_taken(branch_taken),
    .stall(stall), .hazard_new(hazard_new), .ext_evt(ext_evt), .snap_req(snap_req),
    .snap_done(snap_done_a), .rd_addr(rd_addr), .rd_data(rd_data_a), .ovf(ovf_a), .done(done_a));

  mips_perf_counters #(.CNT_W(4), .SATURATE(1'b1)) dut_s (
    .clock(clock), .reset_n(reset_n), .clear(clear), .enable(enable),
    .retire_valid(retire_valid), .retire_class(retire_class), .branch_taken(branch_taken),
    .stall(stall), .hazard_new(hazard_new), .ext_evt(ext_evt), .snap_req(snap_req),
    .snap_done(snap_done_s), .rd_addr(rd_addr), .rd_data(rd_data_s), .ovf(ovf_s), .done(done_s));

  mips_perf_counters #(.CNT_W(4), .SATURATE(1'b0)) dut_w (
    .clock(clock), .reset_n(reset_n), .clear(clear), .enable(enable),
    .retire_valid(retire_valid), .retire_class(retire_class), .branch_taken(branch_taken),
    .stall(stall), .hazard_new(hazard_new), .ext_evt(ext_evt), .snap_req(snap_req),
    .snap_done(snap_done_w), .rd_addr(rd_addr), .rd_data(rd_data_w), .ovf(ovf_w), .done(done_w));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // ---------------- behavioural model: unbounded event counts ----------------
  // mst: 0 idle, 1 run, 2 halted. Counts are kept unbounded; each DUT's
  // width/saturation view is derived from them when comparing.
  int    mst = 0;
  longint cnt [NC] = '{default: 0};
  longint shd [NC] = '{default: 0};
  longint rdv = 0;
  bit    msnap = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mst = 0;
      cnt = '{default: 0};
      shd = '{default: 0};
      rdv = 0;
      msnap = 1'b0;
    end else begin
      longint nx [NC];
      bit on;
      on  = (mst == 1) && enable;
      rdv = (rd_addr < NC) ? shd[rd_addr] : 0;
      nx  = cnt;
      if (on) begin
        nx[0]++;
        if (retire_valid) begin
          nx[1]++;
          case (retire_class)
            3'd0: nx[2]++;
            3'd1: nx[3]++;
            3'd2: nx[4]++;
            3'd3: begin nx[5]++; if (branch_taken) nx[6]++; end
            3'd4: nx[5]++;
            default: ;
          endcase
        end
        if (stall) nx[7]++;
        if (hazard_new) nx[8]++;
        for (int i = 0; i < N_EXT; i++) if (ext_evt[i]) nx[9+i]++;
      end
      if (snap_req) shd = nx;
      msnap = snap_req;
      if (clear) cnt = '{default: 0};
      else cnt = nx;
      if (clear) mst = 0;
      else if (mst == 0 && enable) mst = 1;
      else if (on && retire_valid && retire_class == 3'd4) mst = 2;
    end
  end

  function automatic longint fitv(longint c, int w, bit sat);
    longint mx;
    mx = (longint'(1) << w) - 1;
    if (c > mx) return sat ? mx : (c & mx);
    return c;
  endfunction

  function automatic logic [NC-1:0] ovfv(int w);
    logic [NC-1:0] r;
    longint mx;
    mx = (longint'(1) << w) - 1;
    for (int i = 0; i < NC; i++) r[i] = (cnt[i] > mx);
    return r;
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    chk("done_a", done_a, mst == 2);
    chk("done_s", done_s, mst == 2);
    chk("done_w", done_w, mst == 2);
    chk("snap_done_a", snap_done_a, msnap);
    chk("snap_done_s", snap_done_s, msnap);
    chk("ovf_a", ovf_a, ovfv(32));
    chk("ovf_s", ovf_s, ovfv(4));
    chk("ovf_w", ovf_w, ovfv(4));
    chk("rd_data_a", rd_data_a, fitv(rdv, 32, 1'b1));
    chk("rd_data_s", rd_data_s, fitv(rdv, 4, 1'b1));
    chk("rd_data_w", rd_data_w, fitv(rdv, 4, 1'b0));
  end

  task automatic rd_a(input int a, input longint exp, input string nm);
    rd_addr = AW'(a);
    @(negedge clock);
    chk(nm, rd_data_a, exp);
  endtask

  task automatic snap();
    snap_req = 1'b1;
    @(negedge clock);
    snap_req = 1'b0;
  endtask

  task automatic clear_and_start();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    enable = 1'b1;
    @(negedge clock);  // IDLE -> RUN, not counted
  endtask

  int     cls_seq [12] = '{0, 0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 4};
  longint exp_halt [9] = '{22, 12, 3, 2, 4, 3, 1, 0, 0};
  bit     en_seq  [5]  = '{1, 0, 0, 0, 1};
  bit     hz_seq  [5]  = '{1, 0, 1, 0, 0};

  initial begin
    #1 reset_n = 1'b0;
    @(negedge clock);
    chk("rst_done", done_a, 0);
    chk("rst_rd", rd_data_a, 0);
    chk("rst_ovf", ovf_a, 0);
    #2 reset_n = 1'b1;
    @(negedge clock);

    // 10 counted idle-pipeline cycles
    enable = 1'b1;
    @(negedge clock);
    repeat (10) @(negedge clock);
    enable = 1'b0;
    snap_req = 1'b1;
    @(negedge clock);
    chk("snap_pulse", snap_done_a, 1);
    snap_req = 1'b0;
    rd_addr = '0;
    @(negedge clock);
    chk("cycles10", rd_data_a, 10);
    chk("snap_once", snap_done_a, 0);
    rd_a(1, 0, "instr_none");

    // instruction mix ending in HALT
    enable = 1'b1;
    retire_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      retire_class = 3'(cls_seq[k]);
      branch_taken = (k == 9);
      @(negedge clock);
    end
    chk("done_halt", done_a, 1);
    retire_class = 3'd0;
    branch_taken = 1'b1;
    stall = 1'b1;
    hazard_new = 1'b1;
    ext_evt = '1;
    repeat (4) @(negedge clock);
    retire_valid = 1'b0; branch_taken = 1'b0; stall = 1'b0; hazard_new = 1'b0; ext_evt = '0;
    snap();
    for (int i = 0; i < 9; i++) rd_a(i, exp_halt[i], "halt_mix");
    rd_a(9, 0, "halt_ext0");

    // stall/hazard with enable pausing
    clear_and_start();
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      enable = en_seq[k];
      hazard_new = hz_seq[k];
      @(negedge clock);
    end
    stall = 1'b0; hazard_new = 1'b0; enable = 1'b0;
    snap();
    rd_a(0, 2, "pause_cycles");
    rd_a(7, 2, "stall_cyc");
    rd_a(8, 1, "hazards");

    // overflow on 4-bit counters
    clear_and_start();
    ext_evt = 4'b0001;
    repeat (20) @(negedge clock);
    ext_evt = '0;
    enable = 1'b0;
    snap();
    rd_addr = AW'(9);
    @(negedge clock);
    chk("ext0_sat", rd_data_s, 15);
    chk("ext0_wrap", rd_data_w, 4);
    chk("ovf9_sat", ovf_s[9], 1);
    chk("ovf9_wrap", ovf_w[9], 1);
    chk("ovf9_wide", ovf_a[9], 0);

    // clear together with snapshot
    clear_and_start();
    repeat (7) @(negedge clock);
    enable = 1'b0;
    clear = 1'b1;
    snap_req = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    snap_req = 1'b0;
    chk("clr_ovf_s", ovf_s, 0);
    chk("clr_done", done_a, 0);
    rd_a(0, 7, "clr_snap_cycles");
    rd_a(NC, 0, "rd_out_of_range");

    // randomized traffic with occasional asynchronous resets
    for (int it = 0; it < 3000; it++) begin
      int c;
      enable = ($urandom_range(0, 3) != 0);
      retire_valid = $urandom_range(0, 1);
      c = $urandom_range(0, 5);
      if (c == 4 && $urandom_range(0, 9) != 0) c = 5;
      retire_class = 3'(c);
      branch_taken = $urandom_range(0, 1);
      stall = $urandom_range(0, 1);
      hazard_new = $urandom_range(0, 1);
      ext_evt = N_EXT'($urandom_range(0, 15));
      snap_req = ($urandom_range(0, 5) == 0);
      clear = ($urandom_range(0, 59) == 0);
      rd_addr = AW'($urandom_range(0, 15));
      if (it % 700 == 350) begin
        #2 reset_n = 1'b0;
        #1;
        chk("async_rd", rd_data_a, 0);
        chk("async_snap", snap_done_a, 0);
        chk("async_done", done_a, 0);
        chk("async_ovf", ovf_w, 0);
        @(negedge clock);
        #2 reset_n = 1'b1;
      end
      @(negedge clock);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
